uart_alu_cmd_sequencer: RTL and testbench

- Sits between the UART receive path and the ALU, and sequences each ALU operation.
- Collects a 5-byte command frame from the UART receiver: header, opcode, operand A, operand B, checksum.
- Validates the frame, launches one ALU operation, then returns the result and flags bytes through the UART transmitter handshake.
- Bad frames and inter-byte timeouts are rejected and counted.

---
 rtl/uart_alu_cmd_sequencer_if.sv | 29 ++
 rtl/uart_alu_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_alu_cmd_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_cmd_sequencer_if.sv
// Bundle of the UART receive, ALU and UART transmit handshakes seen by the
// command sequencer. The master side is the sequencer itself; the slave side
// is whatever surrounds it (receiver, ALU, transmitter).
interface uart_alu_cmd_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_start;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic       alu_done;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       busy;
    logic [7:0] err_count;

    modport master (
        input  rx_data, rx_valid, alu_result, alu_flags, alu_done, tx_busy,
        output alu_op, alu_a, alu_b, alu_start, tx_data, tx_start, busy, err_count
    );

    modport slave (
        output rx_data, rx_valid, alu_result, alu_flags, alu_done, tx_busy,
        input  alu_op, alu_a, alu_b, alu_start, tx_data, tx_start, busy, err_count
    );
endinterface

// File: rtl/uart_alu_cmd_sequencer.sv
// Command sequencer between the UART receiver and the ALU. Collects a
// 5-byte frame (header, opcode, A, B, checksum), launches one ALU operation
// and returns the result and flag bytes through the transmitter handshake.
// Bad frames get a NAK byte; inter-byte timeouts silently drop the frame.
// Both kinds of rejection bump a saturating error counter.
module uart_alu_cmd_sequencer #(
    parameter logic [7:0] HEADER       = 8'hAA,
    parameter logic [7:0] NAK_BYTE     = 8'h15,
    parameter int         TIMEOUT_CLKS = 43400
) (
    input logic                      clk,
    input logic                      rst_n,
    uart_alu_cmd_sequencer_if.master bus
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_GET_OP   = 4'd1;
    localparam logic [3:0] S_GET_A    = 4'd2;
    localparam logic [3:0] S_GET_B    = 4'd3;
    localparam logic [3:0] S_GET_CHK  = 4'd4;
    localparam logic [3:0] S_EXEC     = 4'd5;
    localparam logic [3:0] S_WAIT_ALU = 4'd6;
    localparam logic [3:0] S_TX_RES   = 4'd7;
    localparam logic [3:0] S_TX_RES_G = 4'd8;
    localparam logic [3:0] S_TX_FLG   = 4'd9;
    localparam logic [3:0] S_TX_FLG_G = 4'd10;
    localparam logic [3:0] S_TX_NAK   = 4'd11;
    localparam logic [3:0] S_TX_NAK_G = 4'd12;

    // The counter never needs to exceed TIMEOUT_CLKS-1
    localparam int               CNT_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CLKS - 1);

    logic [3:0]       state;
    logic [7:0]       op_reg;
    logic [7:0]       a_reg;
    logic [7:0]       b_reg;
    logic [7:0]       res_reg;
    logic [7:0]       flg_reg;
    logic             guard_first;
    logic [CNT_W-1:0] to_cnt;
    logic [7:0]       err_count;
    logic [3:0]       alu_op;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic             alu_start;
    logic [7:0]       tx_data;
    logic             tx_start;

    logic in_get;
    logic chk_ok;
    logic timeout_hit;
    logic frame_bad;

    // Frame-collection status: which states are timed, checksum/opcode validity, reject events
    always_comb begin
        in_get      = 1'b0;
        chk_ok      = 1'b0;
        timeout_hit = 1'b0;
        frame_bad   = 1'b0;
        in_get      = (state == S_GET_OP) || (state == S_GET_A) ||
                      (state == S_GET_B)  || (state == S_GET_CHK);
        chk_ok      = (bus.rx_data == (op_reg ^ a_reg ^ b_reg)) && (op_reg[7:4] == 4'h0);
        timeout_hit = in_get && !bus.rx_valid && (to_cnt == TO_LIMIT);
        frame_bad   = (state == S_GET_CHK) && bus.rx_valid && !chk_ok;
    end

    // Inter-byte timer: restarts on every received byte and outside frame collection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!in_get || bus.rx_valid || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // Rejected-frame counter, sticks at its maximum instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= 8'h00;
        end else if ((frame_bad || timeout_hit) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end

    // Main sequencer: frame capture, ALU launch, result/flag/NAK transmission
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_reg      <= 8'h00;
            a_reg       <= 8'h00;
            b_reg       <= 8'h00;
            res_reg     <= 8'h00;
            flg_reg     <= 8'h00;
            guard_first <= 1'b0;
            alu_op      <= 4'h0;
            alu_a       <= 8'h00;
            alu_b       <= 8'h00;
            alu_start   <= 1'b0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            tx_start  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.rx_valid && (bus.rx_data == HEADER)) begin
                        state <= S_GET_OP;
                    end
                end
                S_GET_OP: begin
                    if (bus.rx_valid) begin
                        op_reg <= bus.rx_data;
                        state  <= S_GET_A;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_A: begin
                    if (bus.rx_valid) begin
                        a_reg <= bus.rx_data;
                        state <= S_GET_B;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_B: begin
                    if (bus.rx_valid) begin
                        b_reg <= bus.rx_data;
                        state <= S_GET_CHK;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_CHK: begin
                    if (bus.rx_valid) begin
                        if (chk_ok) begin
                            alu_op    <= op_reg[3:0];
                            alu_a     <= a_reg;
                            alu_b     <= b_reg;
                            alu_start <= 1'b1;
                            state     <= S_EXEC;
                        end else begin
                            state <= S_TX_NAK;
                        end
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    state <= S_WAIT_ALU;
                end
                S_WAIT_ALU: begin
                    if (bus.alu_done) begin
                        res_reg <= bus.alu_result;
                        flg_reg <= {4'h0, bus.alu_flags};
                        state   <= S_TX_RES;
                    end
                end
                S_TX_RES: begin
                    if (!bus.tx_busy) begin
                        tx_data     <= res_reg;
                        tx_start    <= 1'b1;
                        guard_first <= 1'b1;
                        state       <= S_TX_RES_G;
                    end
                end
                S_TX_RES_G: begin
                    if (guard_first) begin
                        guard_first <= 1'b0;
                    end else if (!bus.tx_busy) begin
                        state <= S_TX_FLG;
                    end
                end
                S_TX_FLG: begin
                    if (!bus.tx_busy) begin
                        tx_data     <= flg_reg;
                        tx_start    <= 1'b1;
                        guard_first <= 1'b1;
                        state       <= S_TX_FLG_G;
                    end
                end
                S_TX_FLG_G: begin
                    if (guard_first) begin
                        guard_first <= 1'b0;
                    end else if (!bus.tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                S_TX_NAK: begin
                    if (!bus.tx_busy) begin
                        tx_data     <= NAK_BYTE;
                        tx_start    <= 1'b1;
                        guard_first <= 1'b1;
                        state       <= S_TX_NAK_G;
                    end
                end
                S_TX_NAK_G: begin
                    if (guard_first) begin
                        guard_first <= 1'b0;
                    end else if (!bus.tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.err_count = err_count;
    assign bus.alu_op    = alu_op;
    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
    assign bus.alu_start = alu_start;
    assign bus.tx_data   = tx_data;
    assign bus.tx_start  = tx_start;

endmodule

// File: tb/tb_uart_alu_cmd_sequencer.sv
// Directed bench for uart_alu_cmd_sequencer: drives frames byte by byte,
// models a simple ALU and transmitter, and checks each scenario inline.
module tb_uart_alu_cmd_sequencer;

    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_alu_cmd_sequencer_if bus();

    uart_alu_cmd_sequencer #(
        .HEADER      (8'hAA),
        .NAK_BYTE    (8'h15),
        .TIMEOUT_CLKS(T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] tx_log[$];
    int         tx_cnt    = 0;
    int         busy_left = 0;
    int         tx_hold   = 0;
    int         start_cnt = 0;
    int         start_cyc = -1;
    int         alu_delay = 3;
    int         alu_wait  = 0;
    int         last_rx_cyc = 0;
    logic [7:0] alu_res_next = 8'h00;
    logic [3:0] alu_flg_next = 4'h0;
    logic [7:0] exp_err = 8'h00;

    // Free-running cycle index used to measure latencies
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter and ALU models, evaluated just after every rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_start) begin
                tx_log.push_back(bus.tx_data);
                tx_cnt++;
                busy_left = 4;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            bus.tx_busy  = (tx_hold != 0) || (busy_left > 0);
            bus.alu_done = 1'b0;
            if (bus.alu_start) begin
                start_cnt++;
                start_cyc = cyc;
                alu_wait  = alu_delay;
            end else if (alu_wait > 0) begin
                alu_wait--;
                if (alu_wait == 0) begin
                    bus.alu_done   = 1'b1;
                    bus.alu_result = alu_res_next;
                    bus.alu_flags  = alu_flg_next;
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        last_rx_cyc  = cyc;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] chk);
        send_byte(8'hAA);
        send_byte(op);
        send_byte(a);
        send_byte(b);
        send_byte(chk);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s: busy=%b after %0d cycles, expected 0", name, bus.busy, limit);
        end
    endtask

    task automatic clear_logs;
        tx_log.delete();
        tx_cnt    = 0;
        start_cnt = 0;
        start_cyc = -1;
    endtask

    task automatic check_tx2(input string name, input logic [7:0] r, input logic [7:0] f);
        logic [7:0] b0;
        logic [7:0] b1;
        b0 = (tx_log.size() > 0) ? tx_log[0] : 8'bx;
        b1 = (tx_log.size() > 1) ? tx_log[1] : 8'bx;
        checks++;
        if (tx_cnt !== 2) begin
            failures++;
            $display("[TB] FAIL %s_count: got %0d tx bytes expected 2", name, tx_cnt);
        end
        checks++;
        if (b0 !== r) begin
            failures++;
            $display("[TB] FAIL %s_res: got %02h expected %02h", name, b0, r);
        end
        checks++;
        if (b1 !== f) begin
            failures++;
            $display("[TB] FAIL %s_flg: got %02h expected %02h", name, b1, f);
        end
        checks++;
        if (bus.err_count !== exp_err) begin
            failures++;
            $display("[TB] FAIL %s_err: got %02h expected %02h", name, bus.err_count, exp_err);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(3);
        checks++;
        if ({bus.busy, bus.alu_start, bus.tx_start, bus.alu_op, bus.alu_a, bus.alu_b,
             bus.tx_data, bus.err_count} !== 43'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: busy=%b start=%b txs=%b op=%h a=%h b=%h tx=%h err=%h expected all 0",
                     bus.busy, bus.alu_start, bus.tx_start, bus.alu_op, bus.alu_a, bus.alu_b,
                     bus.tx_data, bus.err_count);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_good_frame;
        clear_logs();
        alu_res_next = 8'h46;
        alu_flg_next = 4'h0;
        send_frame(8'h03, 8'h12, 8'h34, 8'h25);
        idle(1);
        checks++;
        if (start_cnt !== 1 || start_cyc !== last_rx_cyc) begin
            failures++;
            $display("[TB] FAIL good_start: got count=%0d cyc=%0d expected count=1 cyc=%0d",
                     start_cnt, start_cyc, last_rx_cyc);
        end
        checks++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {4'h3, 8'h12, 8'h34}) begin
            failures++;
            $display("[TB] FAIL good_operands: got op=%h a=%h b=%h expected op=3 a=12 b=34",
                     bus.alu_op, bus.alu_a, bus.alu_b);
        end
        wait_idle("good_idle", 200);
        check_tx2("good", 8'h46, 8'h00);
        checks++;
        if (start_cnt !== 1) begin
            failures++;
            $display("[TB] FAIL good_single_start: got %0d starts expected 1", start_cnt);
        end
    endtask

    task automatic test_bad_checksum;
        clear_logs();
        send_frame(8'h03, 8'h12, 8'h34, 8'h26);
        wait_idle("badchk_idle", 200);
        exp_err = 8'h01;
        checks++;
        if (start_cnt !== 0) begin
            failures++;
            $display("[TB] FAIL badchk_start: got %0d starts expected 0", start_cnt);
        end
        checks++;
        if (tx_cnt !== 1 || tx_log.size() != 1 || tx_log[0] !== 8'h15) begin
            failures++;
            $display("[TB] FAIL badchk_nak: got %0d tx bytes (first %02h) expected one byte 15",
                     tx_cnt, (tx_log.size() > 0) ? tx_log[0] : 8'h00);
        end
        checks++;
        if (bus.err_count !== exp_err) begin
            failures++;
            $display("[TB] FAIL badchk_err: got %02h expected %02h", bus.err_count, exp_err);
        end
    endtask

    task automatic test_bad_opcode;
        clear_logs();
        send_frame(8'h13, 8'h00, 8'h00, 8'h13);
        wait_idle("badop_idle", 200);
        exp_err = 8'h02;
        checks++;
        if (start_cnt !== 0 || tx_cnt !== 1 || tx_log.size() != 1 || tx_log[0] !== 8'h15) begin
            failures++;
            $display("[TB] FAIL badop_nak: got starts=%0d tx=%0d expected starts=0 one NAK 15",
                     start_cnt, tx_cnt);
        end
        checks++;
        if (bus.err_count !== exp_err) begin
            failures++;
            $display("[TB] FAIL badop_err: got %02h expected %02h", bus.err_count, exp_err);
        end
    endtask

    task automatic test_timeout;
        clear_logs();
        send_byte(8'hAA);
        send_byte(8'h03);
        idle(T - 1);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_early: busy=%b one cycle before limit, expected 1", bus.busy);
        end
        idle(1);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_idle: busy=%b at limit, expected 0", bus.busy);
        end
        exp_err = 8'h03;
        checks++;
        if (bus.err_count !== exp_err || tx_cnt !== 0) begin
            failures++;
            $display("[TB] FAIL timeout_err: got err=%02h tx=%0d expected err=%02h tx=0",
                     bus.err_count, tx_cnt, exp_err);
        end
        // A byte landing exactly on the limit cycle wins over the timeout
        clear_logs();
        alu_res_next = 8'h5A;
        alu_flg_next = 4'hA;
        send_byte(8'hAA);
        send_byte(8'h03);
        idle(T - 1);
        send_byte(8'h12);
        checks++;
        if (bus.busy !== 1'b1 || bus.err_count !== exp_err) begin
            failures++;
            $display("[TB] FAIL limit_accept: got busy=%b err=%02h expected busy=1 err=%02h",
                     bus.busy, bus.err_count, exp_err);
        end
        send_byte(8'h34);
        send_byte(8'h25);
        wait_idle("limit_idle", 200);
        check_tx2("limit", 8'h5A, 8'h0A);
    endtask

    task automatic test_ignore;
        clear_logs();
        send_byte(8'h55);
        idle(2);
        checks++;
        if (bus.busy !== 1'b0 || bus.err_count !== exp_err) begin
            failures++;
            $display("[TB] FAIL idle_ignore: got busy=%b err=%02h expected busy=0 err=%02h",
                     bus.busy, bus.err_count, exp_err);
        end
        alu_delay    = 10;
        alu_res_next = 8'h0C;
        alu_flg_next = 4'h1;
        send_frame(8'h01, 8'h05, 8'h07, 8'h03);
        idle(2);
        send_byte(8'hAA);
        send_byte(8'h03);
        checks++;
        if (bus.busy !== 1'b1 || tx_cnt !== 0) begin
            failures++;
            $display("[TB] FAIL wait_ignore: got busy=%b tx=%0d expected busy=1 tx=0", bus.busy, tx_cnt);
        end
        wait_idle("wait_idle", 200);
        check_tx2("waitrx", 8'h0C, 8'h01);
        alu_delay = 3;
        clear_logs();
        alu_res_next = 8'hF0;
        alu_flg_next = 4'h9;
        send_frame(8'h02, 8'h10, 8'h20, 8'h32);
        wait_idle("next_idle", 200);
        check_tx2("next", 8'hF0, 8'h09);
        checks++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {4'h2, 8'h10, 8'h20} || start_cnt !== 1) begin
            failures++;
            $display("[TB] FAIL next_operands: got op=%h a=%h b=%h starts=%0d expected 2 10 20 1",
                     bus.alu_op, bus.alu_a, bus.alu_b, start_cnt);
        end
    endtask

    task automatic test_tx_hold;
        clear_logs();
        tx_hold      = 1;
        bus.tx_busy  = 1'b1;
        alu_res_next = 8'h3C;
        alu_flg_next = 4'h2;
        send_frame(8'h04, 8'h0F, 8'hF0, 8'hFB);
        idle(23);
        checks++;
        if (tx_cnt !== 0 || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_wait: got tx=%0d busy=%b expected tx=0 busy=1", tx_cnt, bus.busy);
        end
        tx_hold     = 0;
        bus.tx_busy = 1'b0;
        wait_idle("hold_idle", 200);
        check_tx2("hold", 8'h3C, 8'h02);
    endtask

    task automatic test_saturation;
        clear_logs();
        for (int i = 0; i < 256; i++) begin
            send_frame(8'h03, 8'h12, 8'h34, 8'h26);
            wait_idle("sat_idle", 100);
            if (exp_err != 8'hFF) exp_err = exp_err + 8'h01;
        end
        checks++;
        if (bus.err_count !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL sat_err: got %02h expected FF", bus.err_count);
        end
        checks++;
        if (tx_cnt !== 256) begin
            failures++;
            $display("[TB] FAIL sat_naks: got %0d NAKs expected 256", tx_cnt);
        end
    endtask

    task automatic test_reset_mid_frame;
        clear_logs();
        send_byte(8'hAA);
        send_byte(8'h03);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        checks++;
        if ({bus.busy, bus.alu_start, bus.tx_start, bus.alu_op, bus.alu_a, bus.alu_b,
             bus.tx_data, bus.err_count} !== 43'h0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: busy=%b op=%h a=%h b=%h tx=%h err=%h expected all 0",
                     bus.busy, bus.alu_op, bus.alu_a, bus.alu_b, bus.tx_data, bus.err_count);
        end
        exp_err = 8'h00;
        idle(2);
        alu_res_next = 8'h46;
        alu_flg_next = 4'h8;
        send_frame(8'h03, 8'h12, 8'h34, 8'h25);
        wait_idle("midreset_idle", 200);
        check_tx2("midreset", 8'h46, 8'h08);
        checks++;
        if (start_cnt !== 1) begin
            failures++;
            $display("[TB] FAIL midreset_start: got %0d starts expected 1", start_cnt);
        end
    endtask

    // Scenario sequence
    initial begin
        rst_n          = 1'b0;
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.alu_result = 8'h00;
        bus.alu_flags  = 4'h0;
        bus.alu_done   = 1'b0;
        bus.tx_busy    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_opcode();
        test_timeout();
        test_ignore();
        test_tx_hold();
        test_saturation();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
